// File: rtl/hexagon_render_pkg.sv
// Shared constants for the hexagon renderer's DDR write path: widths, arbiter FSM encoding
// and the round-robin pointer helper.
package hexagon_render_pkg;

   localparam int unsigned DDR_ADDR_W  = 32;
   localparam int unsigned PIX_CNT_W   = 32;
   localparam int unsigned MAX_NUM_REQ = 8;
   localparam int unsigned GRANT_IDX_W = $clog2(MAX_NUM_REQ);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StBusy = 2'd1;
   localparam logic [1:0] StGap  = 2'd2;

   // Next round-robin start position after a grant, wrapping at num_req.
   function automatic logic [GRANT_IDX_W-1:0] rr_next(input logic [GRANT_IDX_W-1:0] idx,
                                                      input int unsigned num_req);
      if (32'(idx) + 32'd1 >= num_req) return '0;
      return idx + GRANT_IDX_W'(1);
   endfunction

endpackage

// File: rtl/ddr_write_arbiter_if.sv
// Bundle of draw-engine request slices and the DDR burst-master handshake seen by the arbiter.
interface ddr_write_arbiter_if #(
   parameter int unsigned NUM_REQ = 4
);
   logic [NUM_REQ-1:0]                                  req_txn_init;
   logic [hexagon_render_pkg::DDR_ADDR_W*NUM_REQ-1:0]   req_offset_addr;
   logic [hexagon_render_pkg::PIX_CNT_W*NUM_REQ-1:0]    req_pixel_count;
   logic [NUM_REQ-1:0]                                  req_txn_done;
   logic                                                m_txn_init;
   logic                                                m_txn_done;
   logic [hexagon_render_pkg::DDR_ADDR_W-1:0]           m_offset_addr;
   logic [hexagon_render_pkg::PIX_CNT_W-1:0]            m_pixel_count;
   logic [hexagon_render_pkg::GRANT_IDX_W-1:0]          grant_idx;
   logic                                                busy;
   logic                                                timeout_err;

   // Arbiter side.
   modport slave (
      input  req_txn_init, req_offset_addr, req_pixel_count, m_txn_done,
      output req_txn_done, m_txn_init, m_offset_addr, m_pixel_count, grant_idx, busy,
             timeout_err
   );

   // Engines plus DDR master side.
   modport master (
      output req_txn_init, req_offset_addr, req_pixel_count, m_txn_done,
      input  req_txn_done, m_txn_init, m_offset_addr, m_pixel_count, grant_idx, busy,
             timeout_err
   );
endinterface

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping.
module rr_priority_picker
   import hexagon_render_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]     req_i,
   input  logic [GRANT_IDX_W-1:0] rr_ptr_i,
   output logic [NUM_REQ-1:0]     win_oh_o,
   output logic [GRANT_IDX_W-1:0] win_idx_o,
   output logic                   valid_o
);
   localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic            found;
   logic [IdxW-1:0] idx;

   always_comb begin
      win_oh_o  = '0;
      win_idx_o = '0;
      found     = 1'b0;
      idx       = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = IdxW'((32'(rr_ptr_i) + k) % NUM_REQ);
         if (!found && req_i[idx]) begin
            found         = 1'b1;
            win_oh_o[idx] = 1'b1;
            win_idx_o     = GRANT_IDX_W'(idx);
         end
      end
   end

   assign valid_o = found;

endmodule

// File: rtl/ddr_write_arbiter.sv
// Round-robin arbiter sharing one DDR burst-write master between the frame draw engines;
// latches the winner's offset/count and routes the completion pulse back to it.
module ddr_write_arbiter
   import hexagon_render_pkg::*;
#(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned TIMEOUT_CYCLES = 65536
) (
   input logic                clk100,
   input logic                resetn,
   ddr_write_arbiter_if.slave bus
);
   localparam int unsigned     CntW   = $clog2(TIMEOUT_CYCLES);
   localparam logic [CntW-1:0] CntMax = '1;

   logic [1:0]             state_q, state_d;
   logic [GRANT_IDX_W-1:0] grant_q, grant_d;
   logic [GRANT_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic                   m_init_q, m_init_d;
   logic [DDR_ADDR_W-1:0]  addr_q, addr_d;
   logic [PIX_CNT_W-1:0]   pix_q, pix_d;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic                   tout_q, tout_d;

   logic [NUM_REQ-1:0]     pick_oh;
   logic [GRANT_IDX_W-1:0] pick_idx;
   logic                   pick_valid;
   logic [NUM_REQ-1:0]     done_vec;

   rr_priority_picker #(
      .NUM_REQ (NUM_REQ)
   ) u_picker (
      .req_i     (bus.req_txn_init),
      .rr_ptr_i  (rr_ptr_q),
      .win_oh_o  (pick_oh),
      .win_idx_o (pick_idx),
      .valid_o   (pick_valid)
   );

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      m_init_d = m_init_q;
      addr_d   = addr_q;
      pix_d    = pix_q;
      cnt_d    = cnt_q;
      tout_d   = tout_q;
      case (state_q)
         StIdle: begin
            if (pick_valid) begin
               grant_d  = pick_idx;
               for (int unsigned i = 0; i < NUM_REQ; i++) begin
                  if (pick_oh[i]) begin
                     addr_d = bus.req_offset_addr[DDR_ADDR_W*i +: DDR_ADDR_W];
                     pix_d  = bus.req_pixel_count[PIX_CNT_W*i +: PIX_CNT_W];
                  end
               end
               m_init_d = 1'b1;
               cnt_d    = '0;
               state_d  = StBusy;
            end
         end
         StBusy: begin
            // Saturating: the error flag is sticky and the wait never aborts.
            cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
            if (cnt_d == CntMax) tout_d = 1'b1;
            if (bus.m_txn_done) begin
               m_init_d = 1'b0;
               rr_ptr_d = rr_next(grant_q, NUM_REQ);
               state_d  = StGap;
            end
         end
         StGap:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      done_vec = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         done_vec[i] = (state_q == StBusy) && bus.m_txn_done && (grant_q == GRANT_IDX_W'(i));
      end
   end

   always_ff @(posedge clk100 or negedge resetn) begin
      if (!resetn) begin
         state_q  <= StIdle;
         grant_q  <= '0;
         rr_ptr_q <= '0;
         m_init_q <= 1'b0;
         addr_q   <= '0;
         pix_q    <= '0;
         cnt_q    <= '0;
         tout_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
         m_init_q <= m_init_d;
         addr_q   <= addr_d;
         pix_q    <= pix_d;
         cnt_q    <= cnt_d;
         tout_q   <= tout_d;
      end
   end

   assign bus.req_txn_done  = done_vec;
   assign bus.m_txn_init    = m_init_q;
   assign bus.m_offset_addr = addr_q;
   assign bus.m_pixel_count = pix_q;
   assign bus.grant_idx     = grant_q;
   assign bus.busy          = (state_q == StBusy);
   assign bus.timeout_err   = tout_q;

endmodule

// File: doc/ddr_write_arbiter.md
# ddr_write_arbiter

Round-robin arbiter that shares the single DDR burst-write master between the frame drawing engines (background fill, hexagon, obstacles, cursor). Each engine keeps its own txn_init/txn_done, offset_addr, pixel_count handshake; the arbiter serialises those transactions, latches the winner's address and count, and routes txn_done back only to the granted engine. It sits between the draw engines and the DDR master inside the hexagon renderer.

## Interface
- NUM_REQ, 4, number of requesting draw engines (2..8)
- TIMEOUT_CYCLES, 65536, BUSY cycles before timeout_err sets (power of two, ≥16)
- clk100  in  1  system clock, 100 MHz
- resetn  in  1  asynchronous active-low reset
- req_txn_init  in  NUM_REQ  per-engine request level, held until its txn_done
- req_offset_addr  in  32*NUM_REQ  per-engine byte offset; slice i = bits [32i+31:32i]
- req_pixel_count  in  32*NUM_REQ  per-engine burst length in pixels, same slicing
- req_txn_done  out  NUM_REQ  one-cycle completion pulse to the granted engine only
- m_txn_init  out  1  request level to DDR master
- m_txn_done  in  1  completion pulse from DDR master
- m_offset_addr  out  32  latched offset of current transaction
- m_pixel_count  out  32  latched pixel count of current transaction
- grant_idx  out  3  index of current/last winner
- busy  out  1  high while state is BUSY
- timeout_err  out  1  sticky: a transaction exceeded TIMEOUT_CYCLES

## Operation
- States: IDLE, BUSY, GAP.
- IDLE: if any req_txn_init bit is set, pick the winner as the first set bit at or after rr_ptr, wrapping modulo NUM_REQ. Register grant_idx and latch that slice's offset/count into m_offset_addr/m_pixel_count. Set m_txn_init=1, clear the timeout counter, go BUSY. If no request, stay in IDLE.
- BUSY: hold m_txn_init=1 and the latched outputs stable. The timeout counter increments each cycle. On m_txn_done:
  - req_txn_done[grant_idx]=1 combinationally in the same cycle.
  - m_txn_init←0, rr_ptr←(grant_idx+1) mod NUM_REQ.
  - go GAP.
- GAP: one cycle with m_txn_init=0, then IDLE. This guarantees the DDR master sees a fresh rising edge for every transaction.
- m_txn_done outside BUSY is ignored; req_txn_done stays 0.
- Granted engine dropping req_txn_init during BUSY: the transaction still completes and the done pulse is still delivered.
- Non-granted engine dropping its request before being served: it simply loses arbitration, with no side effects.
- Timeout: when the counter reaches TIMEOUT_CYCLES-1 in BUSY, timeout_err←1 (sticky until reset). The arbiter keeps waiting; there is no abort.
- Inputs are sampled only in IDLE. Changes to non-granted slices during BUSY have no effect on the outputs.

## Timing
- Reset values (asynchronous, all cleared): state=IDLE, m_txn_init=0, m_offset_addr=0, m_pixel_count=0, grant_idx=0, rr_ptr=0, busy=0, timeout_err=0, req_txn_done=0.
- Request-to-issue latency: a request seen in IDLE at edge t gives m_txn_init=1 after edge t (1 cycle). Outputs are registered.
- Done-to-next-issue: with m_txn_done at cycle d, m_txn_init is low in cycles d+1 (GAP) and d+2 (IDLE), and high again from d+3 at the earliest.
- req_txn_done is purely combinational from m_txn_done, gated by state==BUSY and grant_idx.
- Simultaneous requests: resolved in one cycle by rr_ptr order. No requester waits more than NUM_REQ-1 transactions.
- Timeout counter width is log2(TIMEOUT_CYCLES); it saturates and does not wrap.

## Structure
- The shared package hexagon_render_pkg holds:
  - state encoding constants (IDLE=2'd0, BUSY=2'd1, GAP=2'd2)
  - DDR_ADDR_W=32 and PIX_CNT_W=32
  - the max NUM_REQ=8 and the grant_idx width
- One sub-module, rr_priority_picker: combinational, takes the request vector and rr_ptr, returns a one-hot winner plus its index. The FSM, latching and timeout live in the top level.

## Test plan
- Single request: engine 2 raises with offset 0x0000_1000, count 128; DDR done after 20 cycles. Expect m_txn_init high 1 cycle after the request, m_offset_addr=0x1000, m_pixel_count=128, and req_txn_done=4'b0100 for exactly 1 cycle.
- All 4 engines request continuously from reset. Grants must be 0,1,2,3,0,… and m_txn_init must be low for exactly 2 cycles between consecutive grants.
- With rr_ptr=3, engines 1 and 3 request together. Expect grant 3 first, then 1.
- m_txn_done pulsed in IDLE and in GAP: no req_txn_done, no state change.
- resetn asserted mid-BUSY (grant 1, offset 0x2000). All outputs return to reset values immediately, without waiting for a clock edge; after release, a fresh request from engine 0 is granted first.
- TIMEOUT_CYCLES=16 and DDR never responds. timeout_err rises on cycle 16 of BUSY and stays high; a late m_txn_done still completes normally, with timeout_err remaining 1.
